instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width; opcode = bits [15:12], operand = bits [11:0].
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold request from downstream.
- jmp_en  in  1  JMP control bit from the control unit (control bit 7).
- beq_en  in  1  BEQ control bit from the control unit (control bit 3).
- zero_flag  in  1  ALU compare result; qualifies beq_en.
- br_target  in  PC_W  redirect target address.
- imem_addr  out  PC_W  instruction-memory read address.
- imem_rdata  in  INSTR_W  instruction-memory data, valid one cycle after imem_addr.
- opcode  out  4  opcode presented to the control unit.
- operand  out  12  operand field of the presented instruction.
- instr_valid  out  1  opcode/operand hold a real, non-squashed instruction.
- pc_out  out  PC_W  address of the instruction currently on opcode.

Function
REQ-004 SHALL drive imem_addr directly from the PC register.
REQ-005 SHALL have states FILL, RUN, SQUASH.
REQ-006 FILL: entered on reset; lasts exactly 1 non-stalled cycle; PC increments; IR loads NOP (0000), instr_valid=0; next state RUN.
REQ-007 RUN: each non-stalled cycle, PC <= PC+1, opcode/operand <= imem_rdata fields, pc_out <= PC-1 (address of that data), instr_valid <= 1.
REQ-008 Redirect SHALL be defined as jmp_en | (beq_en & zero_flag).
REQ-009 On redirect in any state: PC <= br_target; opcode <= 0000, operand <= 0, instr_valid <= 0; squash counter <= 2; state <= SQUASH.
REQ-010 SQUASH: each non-stalled cycle, PC <= PC+1, IR loads NOP, instr_valid=0, counter decrements; counter reaching 0 -> RUN (first valid instruction is the one at br_target).
REQ-011 Redirect during SQUASH SHALL restart SQUASH with the new target (counter reset to 2).
REQ-012 Redirect SHALL take priority over stall; a redirect in a stalled cycle is applied.
REQ-013 stall without redirect SHALL hold PC, IR, pc_out, instr_valid, state and counter unchanged.
REQ-014 PC increment SHALL wrap modulo 2^PC_W (all-ones + 1 -> 0); br_target used unmodified.
REQ-015 Fetch-to-opcode latency SHALL be 2 cycles (address presented at edge n, opcode valid after edge n+2).

Reset
REQ-016 On rst=1 at a clock edge: PC=0, imem_addr=0, opcode=0000, operand=0, instr_valid=0, pc_out=0, counter=0, state=FILL.
REQ-017 rst SHALL override stall and redirect; reset mid-SQUASH discards the pending target.

Structure
REQ-018 Shared package SHALL hold opcode constants (NOP 0000, ADD 0001, MUL 0010, INC 0011, XOR 0100, CMP 0110, ST 1010, BEQ 1011, RES 1100, LD 1101, JMP 1111), INSTR_W, PC_W and the fetch state enum.
REQ-019 One sub-module, fetch_pc (PC register with increment/load/hold and wrap), SHALL be used; the FSM and IR stay in instr_fetch.

Verification
REQ-020 Reset, then memory holds ADD,MUL,XOR at 0,1,2 -> opcode 0001,0010,0100 on cycles 3,4,5, pc_out 0,1,2, instr_valid=1.
REQ-021 jmp_en=1 with br_target=0x40 while PC=0x05 -> next two opcodes 0000 with instr_valid=0, then instruction at 0x40 with pc_out=0x40.
REQ-022 beq_en=1, zero_flag=0 -> no redirect, sequential fetch continues; beq_en=1, zero_flag=1, br_target=0x10 -> redirect as REQ-021.
REQ-023 stall=1 for 3 cycles in RUN -> PC, opcode, pc_out frozen; resumes with no lost or duplicated instruction.
REQ-024 PC=0xFF in RUN -> next imem_addr=0x00; redirect during SQUASH to 0x20 -> first valid pc_out=0x20.
REQ-025 rst asserted during SQUASH -> all outputs at REQ-016 values next cycle, first valid opcode from address 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the default widths, the opcode constants seen by the control unit,
// the number of bubbles inserted after a redirect, and the fetch state enum.
package instr_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_INC = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_ST  = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_RES = 4'b1100;
  localparam logic [3:0] OP_LD  = 4'b1101;
  localparam logic [3:0] OP_JMP = 4'b1111;

  // Squash down-counter load value on every redirect.
  localparam logic [1:0] SQUASH_SLOTS = 2'd2;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program-counter register for the fetch stage.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset (PC -> 0)
//   load      - load load_val (highest priority after reset)
//   inc       - increment by one, wrapping modulo 2^PC_W
//   load_val  - redirect target, taken unmodified
//   pc        - current program counter
module fetch_pc #(
  parameter int PC_W = instr_fetch_pkg::PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  import instr_fetch_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: drives the instruction-memory address from the PC,
// captures the returned word into the instruction register and inserts
// bubbles after a jump or taken branch.
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   stall                 - downstream hold request
//   jmp_en, beq_en        - control-unit jump / branch-if-equal bits
//   zero_flag             - ALU compare result qualifying beq_en
//   br_target             - redirect target address
//   imem_addr, imem_rdata - instruction memory (data one cycle after address)
//   opcode, operand       - fields of the presented instruction
//   instr_valid           - presented instruction is real, not a bubble
//   pc_out                - address of the presented instruction
//
// state  | meaning
// -------+--------------------------------------------------------------
// FILL   | after reset; one cycle for the first read to come back
// RUN    | sequential fetch, each non-stalled cycle presents a new word
// SQUASH | bubbles after a redirect while the target read is in flight
module instr_fetch #(
  parameter int PC_W    = instr_fetch_pkg::PC_W,
  parameter int INSTR_W = instr_fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jmp_en,
  input  logic               beq_en,
  input  logic               zero_flag,
  input  logic [PC_W-1:0]    br_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [11:0]        operand,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out
);

  import instr_fetch_pkg::*;

  logic [PC_W-1:0]    pc;
  logic               redirect;
  fetch_state_t       state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               ir_load, ir_flush;
  logic               stall_q;
  logic [INSTR_W-1:0] hold_q;
  logic [INSTR_W-1:0] fetch_data;

  assign redirect  = jmp_en | (beq_en & zero_flag);
  assign imem_addr = pc;

  fetch_pc #(.PC_W(PC_W)) u_fetch_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect),
    .inc      (~stall),
    .load_val (br_target),
    .pc       (pc)
  );

  // While the PC is held the memory keeps re-reading the held address, so the
  // word belonging to PC-1 is only on imem_rdata during the first stalled
  // cycle. Capture it there and present it on resume.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      stall_q <= stall & ~redirect;
      if (stall && !redirect && !stall_q) begin
        hold_q <= imem_rdata;
      end
    end
  end

  assign fetch_data = stall_q ? hold_q : imem_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = SQUASH;
    end else if (!stall) begin
      case (state_q)
        FILL:    state_d = RUN;
        RUN:     state_d = RUN;
        SQUASH:  if (cnt_q <= 2'd1) state_d = RUN;
        default: state_d = FILL;
      endcase
    end
  end

  // Output / datapath control. The target word reaches imem_rdata in the
  // SQUASH cycle whose decrement empties the counter, so that cycle loads it
  // rather than a NOP: the redirect cycle and one SQUASH cycle give exactly
  // two bubbles ahead of the target instruction.
  always_comb begin
    ir_load  = 1'b0;
    ir_flush = 1'b0;
    cnt_d    = cnt_q;
    if (redirect) begin
      ir_flush = 1'b1;
      cnt_d    = SQUASH_SLOTS;
    end else if (!stall) begin
      case (state_q)
        FILL: ir_flush = 1'b1;
        RUN:  ir_load  = 1'b1;
        SQUASH: begin
          if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) ir_load  = 1'b1;
          else               ir_flush = 1'b1;
        end
        default: ir_flush = 1'b1;
      endcase
    end
  end

  // Instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode      <= OP_NOP;
      operand     <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
    end else if (ir_flush) begin
      opcode      <= OP_NOP;
      operand     <= '0;
      instr_valid <= 1'b0;
    end else if (ir_load) begin
      opcode      <= fetch_data[15:12];
      operand     <= fetch_data[11:0];
      instr_valid <= 1'b1;
      pc_out      <= pc - PC_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  import instr_fetch_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic               jmp_en;
  logic               beq_en;
  logic               zero_flag;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [3:0]         opcode;
  logic [11:0]        operand;
  logic               instr_valid;
  logic [PC_W-1:0]    pc_out;

  int errors = 0;
  int checks = 0;

  logic [INSTR_W-1:0] mem [256];
  logic [3:0]         ops [10];

  always #5 clk = ~clk;

  // Synchronous instruction memory: word valid one cycle after the address.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jmp_en      (jmp_en),
    .beq_en      (beq_en),
    .zero_flag   (zero_flag),
    .br_target   (br_target),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .pc_out      (pc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_instr(input string tag, input int addr);
    logic [7:0] a;
    a = addr[7:0];
    chk({tag, " opcode"},  16'(opcode),      16'(ops[addr % 10]));
    chk({tag, " operand"}, 16'(operand),     {8'h00, a});
    chk({tag, " pc_out"},  16'(pc_out),      {8'h00, a});
    chk({tag, " valid"},   16'(instr_valid), 16'd1);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " opcode"}, 16'(opcode),      16'(OP_NOP));
    chk({tag, " valid"},  16'(instr_valid), 16'd0);
  endtask

  task automatic chk_addr(input string tag, input logic [7:0] exp);
    chk({tag, " imem_addr"}, 16'(imem_addr), {8'h00, exp});
  endtask

  initial begin
    ops[0] = OP_ADD; ops[1] = OP_MUL; ops[2] = OP_XOR; ops[3] = OP_INC;
    ops[4] = OP_CMP; ops[5] = OP_ST;  ops[6] = OP_BEQ; ops[7] = OP_RES;
    ops[8] = OP_LD;  ops[9] = OP_JMP;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] lo;
      lo = i[7:0];
      mem[i] = {ops[i % 10], 4'h0, lo};
    end

    rst = 1'b1; stall = 1'b0; jmp_en = 1'b0; beq_en = 1'b0;
    zero_flag = 1'b0; br_target = '0;

    // Reset
    tick(); tick();
    chk_addr("rst", 8'h00);
    chk("rst opcode",  16'(opcode),      16'h0);
    chk("rst operand", 16'(operand),     16'h0);
    chk("rst valid",   16'(instr_valid), 16'h0);
    chk("rst pc_out",  16'(pc_out),      16'h0);
    rst = 1'b0;

    // FILL then ADD, MUL, XOR from 0,1,2
    tick(); chk_addr("fill", 8'h01); chk_bubble("fill");
    tick(); chk_instr("seq0", 0); chk_addr("seq0", 8'h02);
    tick(); chk_instr("seq1", 1);
    tick(); chk_instr("seq2", 2); chk_addr("seq2", 8'h04);

    // Stall three cycles in RUN
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_instr("stall", 2); chk_addr("stall", 8'h04);
    end
    stall = 1'b0;
    tick(); chk_instr("resume3", 3); chk_addr("resume3", 8'h05);

    // JMP to 0x40 while PC=0x05
    jmp_en = 1'b1; br_target = 8'h40;
    tick(); chk_bubble("jmp b1"); chk_addr("jmp", 8'h40);
    jmp_en = 1'b0;
    tick(); chk_bubble("jmp b2"); chk_addr("jmp+1", 8'h41);
    tick(); chk_instr("jmp tgt", 'h40);
    tick(); chk_instr("jmp tgt+1", 'h41);

    // BEQ not taken, then taken to 0x10
    beq_en = 1'b1; zero_flag = 1'b0; br_target = 8'h10;
    tick(); chk_instr("beq nt", 'h42); chk_addr("beq nt", 8'h44);
    zero_flag = 1'b1;
    tick(); chk_bubble("beq b1"); chk_addr("beq", 8'h10);
    beq_en = 1'b0; zero_flag = 1'b0;
    tick(); chk_bubble("beq b2");
    tick(); chk_instr("beq tgt", 'h10);

    // Redirect during a stall is applied; then PC wraps past 0xFF
    stall = 1'b1; jmp_en = 1'b1; br_target = 8'hFD;
    tick(); chk_bubble("jmpstall"); chk_addr("jmpstall", 8'hFD);
    stall = 1'b0; jmp_en = 1'b0;
    tick(); chk_bubble("jmpstall b2");
    tick(); chk_instr("wrap fd", 'hFD); chk_addr("wrap", 8'hFF);
    tick(); chk_instr("wrap fe", 'hFE); chk_addr("wrap0", 8'h00);
    tick(); chk_instr("wrap ff", 'hFF);
    tick(); chk_instr("wrap 00", 'h00);

    // Redirect during SQUASH restarts with the new target
    jmp_en = 1'b1; br_target = 8'h30;
    tick(); chk_bubble("sq first");
    br_target = 8'h20;
    tick(); chk_bubble("sq restart"); chk_addr("sq restart", 8'h20);
    jmp_en = 1'b0;
    tick(); chk_bubble("sq b2");
    tick(); chk_instr("sq tgt", 'h20);

    // Reset during SQUASH (with stall high) discards the target
    jmp_en = 1'b1; br_target = 8'h50;
    tick(); chk_bubble("pre rst");
    jmp_en = 1'b0; rst = 1'b1; stall = 1'b1;
    tick();
    chk_addr("rst sq", 8'h00);
    chk("rst sq opcode", 16'(opcode),      16'h0);
    chk("rst sq valid",  16'(instr_valid), 16'h0);
    chk("rst sq pc_out", 16'(pc_out),      16'h0);
    rst = 1'b0; stall = 1'b0;
    tick(); chk_bubble("rst fill"); chk_addr("rst fill", 8'h01);
    tick(); chk_instr("rst first", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
